// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between uart_rx and the console/bus logic.
// A two-state ingest handshake drains uart_rx. The read port is show-ahead.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_ready,
    output logic                  rx_clear,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ack,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  ovr_clear
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {I_IDLE, I_CLEAR} state_t;

    state_t                  state, state_next;
    logic                    clear_next;
    logic                    push_req;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [DEPTH_LOG2-1:0]   head, tail;
    logic [7:0]              mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= I_IDLE;
            rx_clear <= 1'b0;
        end else begin
            state    <= state_next;
            rx_clear <= clear_next;
        end
    end

    // The byte is taken only on the I_IDLE -> I_CLEAR transition, so a long ready level pushes once.
    always_comb begin
        state_next = state;
        clear_next = rx_clear;
        push_req   = 1'b0;
        case (state)
            I_IDLE: begin
                if (rx_data_ready) begin
                    push_req   = 1'b1;
                    clear_next = 1'b1;
                    state_next = I_CLEAR;
                end
            end
            I_CLEAR: begin
                if (!rx_data_ready) begin
                    clear_next = 1'b0;
                    state_next = I_IDLE;
                end
            end
            default: state_next = I_IDLE;
        endcase
    end

    // Full is judged on the pre-edge count, so a simultaneous pop cannot make room.
    assign full     = (count == FULL_COUNT);
    assign rd_valid = (count != '0);
    assign push     = push_req && !full && !flush;
    assign drop     = push_req && full;
    assign pop      = rd_ack && rd_valid && !flush;
    assign rd_data  = mem[head];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clear) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: handshake, ordering, overflow, wrap, flush and async reset.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_clear;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ack;
    logic       flush;
    logic [4:0] count;
    logic       overrun;
    logic       ovr_clear;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_data(rx_data),
        .rx_data_ready(rx_data_ready),
        .rx_clear(rx_clear),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ack(rd_ack),
        .flush(flush),
        .count(count),
        .overrun(overrun),
        .ovr_clear(ovr_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full uart_rx handshake: raise ready, wait for rx_clear, drop ready, wait for release.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data       = b;
        rx_data_ready = 1'b1;
        n = 0;
        do begin step(); n++; end while (!rx_clear && n < 5);
        chk("rx_clear_rise", rx_clear, 1);
        rx_data_ready = 1'b0;
        n = 0;
        do begin step(); n++; end while (rx_clear && n < 5);
        chk("rx_clear_fall", rx_clear, 0);
    endtask

    task automatic pop_byte(input logic [7:0] exp);
        chk("pop_valid", rd_valid, 1);
        chk("pop_data", rd_data, exp);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; rx_data = 8'h00; rx_data_ready = 1'b0;
        rd_ack = 1'b0; flush = 1'b0; ovr_clear = 1'b0;
        step(); step();
        chk("rst_count", count, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_clear", rx_clear, 0);
        reset_n = 1'b1;
        step();

        // three bytes, show-ahead head, then drain
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
        chk("t1_count", count, 3);
        chk("t1_head", rd_data, 8'h41);
        pop_byte(8'h41); pop_byte(8'h42); pop_byte(8'h43);
        chk("t1_empty", rd_valid, 0);
        chk("t1_count0", count, 0);

        // overflow: 17 bytes into 16 slots
        for (int i = 0; i < 17; i++) send_byte(8'(i));
        chk("t2_count", count, 16);
        chk("t2_overrun", overrun, 1);
        chk("t2_head", rd_data, 8'h00);
        // push while full with simultaneous pop: push dropped, pop proceeds
        rx_data = 8'h11; rx_data_ready = 1'b1; rd_ack = 1'b1;
        step();
        rd_ack = 1'b0; rx_data_ready = 1'b0;
        chk("t2_fullpop_count", count, 15);
        step();
        for (int i = 1; i < 16; i++) pop_byte(8'(i));
        chk("t2_empty", rd_valid, 0);
        ovr_clear = 1'b1; step(); ovr_clear = 1'b0;
        chk("t2_ovr_clear", overrun, 0);

        // wrap: 40 bytes with interleaved pops against a queue model
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(8'h80 + i));
            q.push_back(8'(8'h80 + i));
            chk("t3_count", count, q.size());
            if (q.size() >= 3) pop_byte(q.pop_front());
        end
        while (q.size() > 0) pop_byte(q.pop_front());
        chk("t3_empty", rd_valid, 0);
        chk("t3_overrun", overrun, 0);

        // ready held for 10 cycles pushes once
        rx_data = 8'h55; rx_data_ready = 1'b1;
        repeat (10) step();
        rx_data_ready = 1'b0;
        step(); step();
        chk("t4_single", count, 1);
        chk("t4_clear_done", rx_clear, 0);
        pop_byte(8'h55);
        rd_ack = 1'b1; step(); rd_ack = 1'b0;
        chk("t4_ack_empty", count, 0);
        chk("t4_valid", rd_valid, 0);

        // flush + pop + ingest in the same cycle
        for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i));
        chk("t5_count5", count, 5);
        rx_data = 8'h99; rx_data_ready = 1'b1; flush = 1'b1; rd_ack = 1'b1;
        step();
        flush = 1'b0; rd_ack = 1'b0;
        chk("t5_count", count, 0);
        chk("t5_valid", rd_valid, 0);
        chk("t5_clear_hi", rx_clear, 1);
        rx_data_ready = 1'b0;
        step();
        chk("t5_clear_lo", rx_clear, 0);
        chk("t5_still_empty", count, 0);
        send_byte(8'h77);
        chk("t5_after", count, 1);
        pop_byte(8'h77);

        // async reset while in I_CLEAR with count=3
        send_byte(8'h31); send_byte(8'h32);
        rx_data = 8'h33; rx_data_ready = 1'b1;
        step();
        chk("t6_count3", count, 3);
        chk("t6_in_clear", rx_clear, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_clear", rx_clear, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_overrun", overrun, 0);
        rx_data_ready = 1'b0;
        #1 reset_n = 1'b1;
        step();
        send_byte(8'h5A);
        chk("t6_next_count", count, 1);
        pop_byte(8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
